seq_divider: RTL and testbench

Parametrised iterative radix-2 restoring divider, signed/unsigned, the next generation of the team's sequential divide unit. It adds valid/ready handshakes on both sides, a WIDTH parameter, explicit divide-by-zero and signed-overflow results, and optional leading-zero early termination. It sits behind the core's execute-stage issue logic as a multi-cycle functional unit.

---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider_lzc.sv | 19 +
 rtl/seq_divider.sv | 182 ++++++++++++++++++
 tb/tb_seq_divider.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the iterative radix-2 restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

  // Widest operand the magnitude helper supports; callers sign-extend into it.
  localparam int unsigned MaxWidth = 128;

  function automatic logic [MaxWidth-1:0] twos_mag(input logic [MaxWidth-1:0] x);
    return x[MaxWidth-1] ? -x : x;
  endfunction

endpackage

// File: rtl/seq_divider_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module seq_divider_lzc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]              value,
  output logic [$clog2(WIDTH+1)-1:0]    count
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit wins.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, signed/unsigned, valid/ready on both sides.
// Optional leading-zero early termination: define SEQ_DIVIDER_EARLY_TERM_EN.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             usigned_n,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, init_cnt;
  logic [WIDTH-1:0] rem_q, rem_d, q_q, q_d, dr_mag_q, dr_mag_d;
  logic [WIDTH-1:0] quot_q, quot_d, rmd_q, rmd_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic             ovf_pend_q, ovf_pend_d, ovf_q, ovf_d, dbz_q, dbz_d;

  logic                accept, is_signed, dd_neg, dr_neg, is_ovf;
  logic [WIDTH-1:0]    dd_mag, dr_mag, q_init;
  logic [MaxWidth-1:0] dd_ext, dr_ext;
  logic [WIDTH:0]      trial;

  // Reset already holds every flop, so accept needs only the state.
  assign accept    = in_valid && (state_q == IDLE);
  assign is_signed = ~usigned_n;
  assign dd_neg    = is_signed & dividend[WIDTH-1];
  assign dr_neg    = is_signed & divisor[WIDTH-1];
  assign dd_ext    = {{(MaxWidth - WIDTH){dd_neg}}, dividend};
  assign dr_ext    = {{(MaxWidth - WIDTH){dr_neg}}, divisor};
  assign dd_mag    = WIDTH'(twos_mag(dd_ext));
  assign dr_mag    = WIDTH'(twos_mag(dr_ext));
  assign is_ovf    = is_signed && (dividend == {1'b1, {(WIDTH - 1){1'b0}}}) && (&divisor);
  assign trial     = {rem_q, q_q[WIDTH-1]} - {1'b0, dr_mag_q};

`ifdef SEQ_DIVIDER_EARLY_TERM_EN
  logic [CNT_W-1:0] lz;

  seq_divider_lzc #(
    .WIDTH(WIDTH)
  ) u_lzc (
    .value(dd_mag),
    .count(lz)
  );

  // Skip the leading zeros: they would only shift zero quotient bits in.
  assign q_init   = dd_mag << lz;
  assign init_cnt = CNT_W'(WIDTH) - lz;
`else
  assign q_init   = dd_mag;
  assign init_cnt = CNT_W'(WIDTH);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (divisor == '0)        state_d = DONE;
          else if (init_cnt == '0)  state_d = FIX;
          else                      state_d = CALC;
        end
      end
      CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = rst_n && (state_q == IDLE);
    out_valid   = (state_q == DONE);
    busy        = (state_q != IDLE);
    quotient    = quot_q;
    remainder   = rmd_q;
    div_by_zero = dbz_q;
    overflow    = ovf_q;
  end

  always_comb begin
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    q_d        = q_q;
    dr_mag_d   = dr_mag_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    ovf_pend_d = ovf_pend_q;
    quot_d     = quot_q;
    rmd_d      = rmd_q;
    ovf_d      = ovf_q;
    dbz_d      = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          quot_d = '0;
          rmd_d  = '0;
          ovf_d  = 1'b0;
          dbz_d  = 1'b0;
          if (divisor == '0) begin
            quot_d = '1;
            rmd_d  = dividend;
            dbz_d  = 1'b1;
          end else begin
            rem_d      = '0;
            q_d        = q_init;
            cnt_d      = init_cnt;
            dr_mag_d   = dr_mag;
            neg_quo_d  = dd_neg ^ dr_neg;
            neg_rem_d  = dd_neg;
            ovf_pend_d = is_ovf;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], q_q[WIDTH-1]};
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
      end
      FIX: begin
        quot_d = neg_quo_q ? -q_q : q_q;
        rmd_d  = neg_rem_q ? -rem_q : rem_q;
        ovf_d  = ovf_pend_q;
      end
      DONE:    ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      q_q        <= '0;
      dr_mag_q   <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      quot_q     <= '0;
      rmd_q      <= '0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      q_q        <= q_d;
      dr_mag_q   <= dr_mag_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      ovf_pend_q <= ovf_pend_d;
      quot_q     <= quot_d;
      rmd_q      <= rmd_d;
      ovf_q      <= ovf_d;
      dbz_q      <= dbz_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32), both build flavours.
module tb_seq_divider;

  localparam int unsigned W = 32;
`ifdef SEQ_DIVIDER_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         usigned_n = 1'b1;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;
  logic         busy;

  int errors = 0;
  int checks = 0;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .usigned_n(usigned_n),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         uns;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edbz;
    logic         eovf;
  } vec_t;

  // Stimulus only: issue one operation from IDLE, wait for the result, then release it.
  task automatic do_op(input logic uns, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dbz, output logic ovf, output int cyc, output bit tmo);
    usigned_n = uns;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    tmo = !out_valid;
    q   = quotient;
    r   = remainder;
    dbz = div_by_zero;
    ovf = overflow;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if ({out_valid, busy, div_by_zero, overflow} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {out_valid, busy, div_by_zero, overflow});
    end
    checks++;
    if ({quotient, remainder} !== 64'h0) begin
      errors++; $display("FAIL reset_results: got %h/%h expected 0/0", quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_latency();
    logic [W-1:0] q, r;
    logic dbz, ovf;
    int cyc;
    bit tmo;
    do_op(1'b1, 32'd100, 32'd7, q, r, dbz, ovf, cyc, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL u100_7_timeout: got no out_valid expected out_valid"); end
    checks++;
    if (q !== 32'd14 || r !== 32'd2) begin
      errors++; $display("FAIL u100_7_result: got %0d/%0d expected 14/2", q, r);
    end
    checks++;
    if (dbz !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL u100_7_flags: got dbz=%b ovf=%b expected 0/0", dbz, ovf);
    end
    checks++;
    if (cyc !== (EarlyTerm ? 9 : 34)) begin
      errors++; $display("FAIL u100_7_latency: got %0d expected %0d", cyc, EarlyTerm ? 9 : 34);
    end
    do_op(1'b1, 32'd0, 32'd3, q, r, dbz, ovf, cyc, tmo);
    checks++;
    if (tmo || q !== 32'd0 || r !== 32'd0) begin
      errors++; $display("FAIL u0_3_result: got %h/%h tmo=%b expected 0/0", q, r, tmo);
    end
    checks++;
    if (cyc !== (EarlyTerm ? 2 : 34)) begin
      errors++; $display("FAIL u0_3_latency: got %0d expected %0d", cyc, EarlyTerm ? 2 : 34);
    end
  endtask

  task automatic test_vectors();
    vec_t v[9];
    logic [W-1:0] q, r;
    logic dbz, ovf;
    int cyc;
    bit tmo;
    v[0] = '{1'b0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
    v[1] = '{1'b0, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1,        1'b0, 1'b0};
    v[2] = '{1'b0, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0};
    v[3] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0, 1'b1};
    v[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 1'b0};
    v[5] = '{1'b1, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        1'b0, 1'b0};
    v[6] = '{1'b1, 32'd7,        32'd9,        32'd0,        32'd7,        1'b0, 1'b0};
    v[7] = '{1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0};
    v[8] = '{1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd7,        32'd0,        1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      do_op(v[i].uns, v[i].a, v[i].b, q, r, dbz, ovf, cyc, tmo);
      checks++;
      if (tmo || q !== v[i].eq || r !== v[i].er || dbz !== v[i].edbz || ovf !== v[i].eovf) begin
        errors++;
        $display("FAIL vec%0d: got q=%h r=%h dbz=%b ovf=%b tmo=%b expected q=%h r=%h dbz=%b ovf=%b",
                 i, q, r, dbz, ovf, tmo, v[i].eq, v[i].er, v[i].edbz, v[i].eovf);
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic [W-1:0] q, r;
    logic dbz, ovf;
    int cyc;
    bit tmo;
    do_op(1'b0, 32'h80000000, 32'h0, q, r, dbz, ovf, cyc, tmo);
    checks++;
    if (tmo || q !== 32'hFFFFFFFF || r !== 32'h80000000) begin
      errors++; $display("FAIL dbz_result: got %h/%h expected ffffffff/80000000", q, r);
    end
    checks++;
    if (dbz !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL dbz_flags: got dbz=%b ovf=%b expected 1/0", dbz, ovf);
    end
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    usigned_n = 1'b1;
    dividend  = 32'd100;
    divisor   = 32'd7;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    dividend = 32'd50;
    divisor  = 32'd5;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (!out_valid) begin errors++; $display("FAIL bp_timeout: got no out_valid expected out_valid"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (quotient !== 32'd14 || remainder !== 32'd2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: got q=%0d r=%0d rdy=%b ov=%b expected 14/2/0/1",
                 i, quotient, remainder, in_ready, out_valid);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: got rdy=%b ov=%b busy=%b expected 1/0/0", in_ready, out_valid, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL bp_accept: got busy=%b q=%h r=%h expected 1/0/0", busy, quotient, remainder);
    end
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (!out_valid || quotient !== 32'd10 || remainder !== 32'd0) begin
      errors++; $display("FAIL bp_second: got ov=%b q=%0d r=%0d expected 1/10/0", out_valid, quotient, remainder);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int seen;
    usigned_n = 1'b1;
    dividend  = 32'hFFFFFFFF;
    divisor   = 32'd3;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mr_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, in_ready} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      errors++; $display("FAIL mr_clear: got busy=%b ov=%b rdy=%b q=%h r=%h expected all 0",
                         busy, out_valid, in_ready, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_ready: got %b expected 1", in_ready); end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mr_no_result: got %0d valid cycles expected 0", seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_unsigned_latency();
    test_vectors();
    test_div_by_zero();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
